// File: rtl/enc_onehot2bin.sv
// One-hot to binary encoder with a one-entry registered valid/ready output stage (1-cycle latency,
// in_ready_o = !out_valid_o | out_ready_i). Optional saturating error counter under ENC_ERRCNT_EN.
module enc_onehot2bin #(
  parameter int WIDTH = 15,
  parameter int BW    = 4
`ifdef ENC_ERRCNT_EN
  , parameter int CNT_W = 8
`endif
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [BW-1:0]    out_o,
  output logic             out_err_o
`ifdef ENC_ERRCNT_EN
  , input  logic             err_clr_i
  , output logic [CNT_W-1:0] err_cnt_o
`endif
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_e;

  state_e          state_q, state_d;
  logic [BW-1:0]   out_q, out_d;
  logic            err_q, err_d;
  logic [BW-1:0]   enc_idx;
  logic            enc_err;
  logic            accept;
  logic            drain;

  // Scan downward so the lowest set bit wins when several are set.
  always_comb begin
    enc_idx = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (in_i[i]) enc_idx = BW'(i);
    end
  end

  // Exactly one-hot: nonzero and clearing the lowest set bit leaves nothing.
  assign enc_err = (in_i == '0) || ((in_i & (in_i - WIDTH'(1))) != '0);

  assign out_valid_o = (state_q == FULL);
  assign in_ready_o  = !out_valid_o || out_ready_i;
  assign accept      = in_valid_i && in_ready_o;
  assign drain       = out_valid_o && out_ready_i;

  // Result registers load only on accept, so input bits are never sampled while in_valid_i=0.
  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    err_d   = err_q;
    unique case (state_q)
      EMPTY:   if (accept) state_d = FULL;
      FULL:    if (drain && !accept) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
    if (accept) begin
      out_d = enc_idx;
      err_d = enc_err;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= EMPTY;
      out_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      err_q   <= err_d;
    end
  end

  assign out_o     = out_q;
  assign out_err_o = err_q;

`ifdef ENC_ERRCNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_acc;

  assign err_acc = accept && enc_err;

  // A clear coinciding with an errored accept still counts that word.
  always_comb begin
    cnt_d = cnt_q;
    if (err_clr_i)                     cnt_d = err_acc ? CNT_W'(1) : '0;
    else if (err_acc && cnt_q != '1)   cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign err_cnt_o = cnt_q;
`endif

endmodule

// File: tb/tb_enc_onehot2bin.sv
// Directed bench for enc_onehot2bin: behavioural reference model checked every cycle plus literal checks.
module tb_enc_onehot2bin;

  localparam int WIDTH = 15;
  localparam int BW    = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_w = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [BW-1:0]    out_b;
  logic             out_err;
`ifdef ENC_ERRCNT_EN
  logic             err_clr = 1'b0;
  logic [7:0]       err_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  enc_onehot2bin #(.WIDTH(WIDTH), .BW(BW)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_i        (in_w),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_o       (out_b),
    .out_err_o   (out_err)
`ifdef ENC_ERRCNT_EN
    , .err_clr_i (err_clr)
    , .err_cnt_o (err_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference encoding: isolate lowest set bit arithmetically, error unless popcount is exactly one.
  function automatic void ref_enc(input logic [WIDTH-1:0] w, output int idx, output bit err);
    logic [WIDTH-1:0] low;
    low = w & (~w + 1'b1);
    idx = (w == '0) ? 0 : $clog2(low);
    err = ($countones(w) != 1);
  endfunction

  bit m_valid = 0;
  int m_out   = 0;
  bit m_err   = 0;
  int m_cnt   = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid = 0; m_out = 0; m_err = 0; m_cnt = 0;
    end else begin
      bit acc;
      int idx;
      bit e;
      acc = in_valid && (!m_valid || out_ready);
      if (acc) begin
        ref_enc(in_w, idx, e);
        m_valid = 1; m_out = idx; m_err = e;
      end else if (m_valid && out_ready) begin
        m_valid = 0;
      end
`ifdef ENC_ERRCNT_EN
      if (err_clr)               m_cnt = (acc && e) ? 1 : 0;
      else if (acc && e && m_cnt < 255) m_cnt = m_cnt + 1;
`endif
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("cyc_out_valid", 32'(out_valid), 32'(m_valid));
      check("cyc_in_ready", 32'(in_ready), 32'(!m_valid || out_ready));
      if (m_valid) begin
        check("cyc_out", 32'(out_b), 32'(m_out));
        check("cyc_out_err", 32'(out_err), 32'(m_err));
      end
`ifdef ENC_ERRCNT_EN
      check("cyc_err_cnt", 32'(err_cnt), 32'(m_cnt));
`endif
    end
  end

  // Present a word and step one edge; outputs are then sampled 1 time unit after that edge.
  task automatic send(input logic [WIDTH-1:0] w);
    in_w = w; in_valid = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    int run;
    // Reset held with a valid word on the input.
    rst_n = 1'b0; in_valid = 1'b1; in_w = 15'h0008;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out", 32'(out_b), 0);
    check("rst_out_err", 32'(out_err), 0);
`ifdef ENC_ERRCNT_EN
    check("rst_err_cnt", 32'(err_cnt), 0);
`endif
    in_valid = 1'b0;
    rst_n = 1'b1;
    #1;
    check("rst_in_ready", 32'(in_ready), 1);

    // Full sweep at one word per cycle.
    out_ready = 1'b1;
    @(posedge clk); #1;
    run = 0;
    for (int i = 0; i < WIDTH; i++) begin
      send(WIDTH'(1) << i);
      check("sweep_out", 32'(out_b), 32'(i));
      check("sweep_err", 32'(out_err), 0);
      if (out_valid) run++;
    end
    check("sweep_valid_run", 32'(run), 15);

    // Encoding error cases.
    send(15'h0000);
    check("zero_out", 32'(out_b), 0);
    check("zero_err", 32'(out_err), 1);
    send(15'h0050);
    check("multi_out", 32'(out_b), 4);
    check("multi_err", 32'(out_err), 1);
    send(15'h4000);
    check("top_out", 32'(out_b), 14);
    check("top_err", 32'(out_err), 0);

    // Idle cycles with unknown input data must not disturb state.
    in_w = 'x;
    idle(3);
    check("idle_valid", 32'(out_valid), 0);

    // Backpressure.
    out_ready = 1'b0;
    send(15'h0008);
    check("bp_out", 32'(out_b), 3);
    in_w = 15'h0200;
    repeat (3) begin @(posedge clk); #1; end
    check("bp_hold_out", 32'(out_b), 3);
    check("bp_hold_valid", 32'(out_valid), 1);
    check("bp_in_ready", 32'(in_ready), 0);
    out_ready = 1'b1;
    #1;
    check("bp_release_rdy", 32'(in_ready), 1);
    @(posedge clk); #1;
    check("bp_new_out", 32'(out_b), 9);
    check("bp_new_err", 32'(out_err), 0);
    idle(1);

`ifdef ENC_ERRCNT_EN
    for (int i = 0; i < 300; i++) send(15'h0003);
    check("cnt_sat", 32'(err_cnt), 255);
    err_clr = 1'b1;
    send(15'h0000);
    err_clr = 1'b0;
    check("cnt_clr_err", 32'(err_cnt), 1);
    send(15'h0002);
    check("cnt_clean", 32'(err_cnt), 1);
    err_clr = 1'b1;
    idle(1);
    err_clr = 1'b0;
    check("cnt_clr", 32'(err_cnt), 0);
`endif

    // Asynchronous reset while holding a result.
    out_ready = 1'b0;
    send(15'h0020);
    check("ar_out", 32'(out_b), 5);
    check("ar_valid", 32'(out_valid), 1);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_valid_drop", 32'(out_valid), 0);
    check("ar_out_clr", 32'(out_b), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    idle(2);
    check("ar_post_valid", 32'(out_valid), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
